// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bundle: ROM request/response port plus the ID-side instruction head.
// "master" is the fetch engine; "slave" is the ROM/decode environment around it.
interface fetch_prefetch_queue_if;
    logic        i_req;
    logic [31:0] i_address;
    logic        i_data_valid;
    logic [31:0] i_data_read;
    logic        jump;
    logic [31:0] jump_addr;
    logic        stall;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_fault;

    modport master (
        output i_req, i_address, ins_valid, ins_data, ins_pc, ins_fault,
        input  i_data_valid, i_data_read, jump, jump_addr, stall
    );

    modport slave (
        input  i_req, i_address, ins_valid, ins_data, ins_pc, ins_fault,
        output i_data_valid, i_data_read, jump, jump_addr, stall
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch engine with a DEPTH-entry prefetch queue in front of a variable-latency ROM.
// Redirects flush the queue and drop responses still in flight; misaligned targets park a fault entry.
module fetch_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_prefetch_queue_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 2;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    logic        fault_mem [DEPTH];

    ptr_t        rd_ptr;
    ptr_t        wr_ptr;
    cnt_t        count;
    cnt_t        outstanding;
    cnt_t        discard;
    logic [31:0] fetch_pc;
    logic [31:0] resp_pc;
    logic        halted;

    logic        head_valid;
    logic        pop;
    logic        resp;
    logic        keep;
    logic        drop;
    logic        issue;
    logic        misaligned;
    cnt_t        occupancy;
    cnt_t        in_flight_after;

    always_comb begin
        head_valid      = (count != '0);
        pop             = head_valid && !bus.stall && !bus.jump;
        // A response with nothing outstanding is a protocol error and is ignored outright.
        resp            = bus.i_data_valid && (outstanding != '0);
        drop            = resp && (discard != '0);
        keep            = resp && (discard == '0) && !bus.jump;
        misaligned      = (bus.jump_addr[1:0] != 2'b00);
        occupancy       = count + outstanding - (pop ? CNT_ONE : '0);
        issue           = !reset && !bus.jump && !halted && (occupancy < DEPTH_C);
        in_flight_after = outstanding - (resp ? CNT_ONE : '0);
    end

    assign bus.i_req     = issue;
    assign bus.i_address = fetch_pc;
    assign bus.ins_valid = head_valid;
    assign bus.ins_data  = head_valid ? instr_mem[rd_ptr] : '0;
    assign bus.ins_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
    assign bus.ins_fault = head_valid ? fault_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            halted      <= 1'b0;
        end else if (bus.jump) begin
            // Everything still in flight, minus a response landing this cycle, is now stale.
            rd_ptr      <= '0;
            wr_ptr      <= misaligned ? PTR_ONE : '0;
            count       <= misaligned ? CNT_ONE : '0;
            outstanding <= in_flight_after;
            discard     <= in_flight_after;
            fetch_pc    <= bus.jump_addr;
            resp_pc     <= bus.jump_addr;
            halted      <= misaligned;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (keep) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                resp_pc <= resp_pc + 32'd4;
            end
            if (drop) begin
                discard <= discard - CNT_ONE;
            end
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            count       <= count + (keep ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
            outstanding <= in_flight_after + (issue ? CNT_ONE : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (bus.jump) begin
            if (misaligned) begin
                pc_mem[0]    <= bus.jump_addr;
                instr_mem[0] <= '0;
                fault_mem[0] <= 1'b1;
            end
        end else if (keep) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= bus.i_data_read;
            fault_mem[wr_ptr] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= DEPTH_C);
            assert (outstanding <= DEPTH_C);
            assert (discard <= outstanding);
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Randomised bench for fetch_prefetch_queue: queue-based reference model plus directed literal checks.
// A ROM model answers the DUT's requests in order with programmable or random latency.
module tb_fetch_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        fault;
    } entry_t;

    typedef struct {
        logic [31:0] pc;
        logic        live;
    } flight_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rom_t;

    logic clk;
    logic reset;

    fetch_prefetch_queue_if bus ();

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk   = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int rel     = -1;
    int rom_lat = 1;
    int last_due = 0;
    int stale_n = 0;

    entry_t  mq[$];
    flight_t inflight[$];
    rom_t    rom_q[$];
    logic [31:0] m_fpc    = RESET_PC;
    logic        m_halted = 1'b0;

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return {addr[15:0] ^ 16'h5A5A, ~addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic model_cycle(input logic j, input logic [31:0] ja, input logic st);
        logic    exp_valid;
        logic    pop;
        logic    exp_req;
        int      occ;
        int      lat;
        entry_t  e;
        flight_t f;
        rom_t    r;

        exp_valid = (mq.size() != 0);
        chk("ins_valid", bus.ins_valid, exp_valid);
        if (exp_valid) begin
            chk("ins_pc", bus.ins_pc, mq[0].pc);
            chk("ins_data", bus.ins_data, mq[0].ins);
            chk("ins_fault", bus.ins_fault, mq[0].fault);
        end else begin
            chk("empty_data", bus.ins_data, 32'h0);
            chk("empty_pc", bus.ins_pc, 32'h0);
            chk("empty_fault", bus.ins_fault, 1'b0);
        end

        pop     = exp_valid && !st && !j;
        occ     = mq.size() + inflight.size() - (pop ? 1 : 0);
        exp_req = !j && !m_halted && (occ < DEPTH);
        chk("i_req", bus.i_req, exp_req);
        if (exp_req)
            chk("i_address", bus.i_address, m_fpc);

        // The ROM answers whatever the DUT actually asked for.
        if (bus.i_req) begin
            lat    = (rom_lat == 0) ? int'($urandom_range(1, 4)) : rom_lat;
            r.addr = bus.i_address;
            r.due  = cyc + lat;
            if (r.due <= last_due)
                r.due = last_due + 1;
            last_due = r.due;
            rom_q.push_back(r);
        end

        if (pop)
            void'(mq.pop_front());
        if (bus.i_data_valid && inflight.size() != 0) begin
            f = inflight.pop_front();
            if (f.live && !j) begin
                e.pc    = f.pc;
                e.ins   = rom_word(f.pc);
                e.fault = 1'b0;
                mq.push_back(e);
            end
        end

        if (j) begin
            mq.delete();
            foreach (inflight[k])
                inflight[k].live = 1'b0;
            m_fpc    = ja;
            m_halted = (ja[1:0] != 2'b00);
            if (m_halted) begin
                e.pc    = ja;
                e.ins   = 32'h0;
                e.fault = 1'b1;
                mq.push_back(e);
            end
        end else if (exp_req) begin
            f.pc   = m_fpc;
            f.live = 1'b1;
            inflight.push_back(f);
            m_fpc = m_fpc + 32'd4;
        end
    endtask

    task automatic step(input logic rst, input logic j, input logic [31:0] ja, input logic st);
        @(posedge clk);
        #1;
        cyc++;
        reset = rst;
        if (rst)
            rel = -1;
        else
            rel++;

        if (stale_n > 0) begin
            bus.i_data_valid = 1'b1;
            bus.i_data_read  = 32'hBAD0_0000 | $urandom_range(0, 255);
            stale_n--;
        end else if (rom_q.size() != 0 && rom_q[0].due <= cyc) begin
            bus.i_data_valid = 1'b1;
            bus.i_data_read  = rom_word(rom_q[0].addr);
            void'(rom_q.pop_front());
        end else begin
            bus.i_data_valid = 1'b0;
            bus.i_data_read  = $urandom;
        end
        bus.jump      = j;
        bus.jump_addr = ja;
        bus.stall     = st;

        @(negedge clk);
        if (rst) begin
            chk("rst_i_req", bus.i_req, 1'b0);
            chk("rst_i_address", bus.i_address, RESET_PC);
            chk("rst_ins_valid", bus.ins_valid, 1'b0);
            chk("rst_ins_data", bus.ins_data, 32'h0);
            chk("rst_ins_pc", bus.ins_pc, 32'h0);
            chk("rst_ins_fault", bus.ins_fault, 1'b0);
            mq.delete();
            inflight.delete();
            m_fpc    = RESET_PC;
            m_halted = 1'b0;
        end else begin
            model_cycle(j, ja, st);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.jump         = 1'b0;
        bus.jump_addr    = '0;
        bus.stall        = 1'b0;
        bus.i_data_valid = 1'b0;
        bus.i_data_read  = '0;

        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // Reset release, L=1: one request per cycle, first head two cycles later.
        rom_lat = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (i == 0) begin
                chk("first_req", bus.i_req, 1'b1);
                chk("first_addr", bus.i_address, RESET_PC);
            end
            if (i == 2) begin
                chk("first_head_valid", bus.ins_valid, 1'b1);
                chk("first_head_pc", bus.ins_pc, RESET_PC);
            end
            if (i == 3)
                chk("second_head_pc", bus.ins_pc, RESET_PC + 32'd4);
        end

        // L=3 with an 8-cycle decode stall: the queue fills and requests stop.
        rom_lat = 3;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 1'b0, 32'h0, (i >= 10 && i < 18));
            if (i == 17) begin
                chk("full_no_req", bus.i_req, 1'b0);
                chk("full_head_valid", bus.ins_valid, 1'b1);
            end
        end

        // Redirect to 0x100 with three responses in flight, one landing in the jump cycle.
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (k == 1) begin
                chk("jmp_gap_valid", bus.ins_valid, 1'b0);
                chk("jmp_req", bus.i_req, 1'b1);
                chk("jmp_addr", bus.i_address, 32'h0000_0100);
            end
            if (k >= 2 && k <= 4)
                chk("jmp_stale_dropped", bus.ins_valid, 1'b0);
            if (k == 5) begin
                chk("jmp_head_valid", bus.ins_valid, 1'b1);
                chk("jmp_head_pc", bus.ins_pc, 32'h0000_0100);
                chk("jmp_head_data", bus.ins_data, rom_word(32'h0000_0100));
            end
        end

        // Misaligned redirect parks a fault entry and halts fetch until the next jump.
        step(1'b0, 1'b1, 32'h0000_0102, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("fault_valid", bus.ins_valid, 1'b1);
        chk("fault_flag", bus.ins_fault, 1'b1);
        chk("fault_pc", bus.ins_pc, 32'h0000_0102);
        chk("fault_data", bus.ins_data, 32'h0);
        chk("fault_no_req", bus.i_req, 1'b0);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("halt_no_req", bus.i_req, 1'b0);
        rom_lat = 2;
        step(1'b0, 1'b1, 32'h0000_0200, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("resume_req", bus.i_req, 1'b1);
        chk("resume_addr", bus.i_address, 32'h0000_0200);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0);

        // Fetch address wraps from 0xFFFF_FFFC to 0.
        rom_lat = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (k == 1)
                chk("wrap_first_addr", bus.i_address, 32'hFFFF_FFF0);
            if (k == 3)
                chk("wrap_first_head", bus.ins_pc, 32'hFFFF_FFF0);
            if (k == 4)
                chk("wrap_last_addr", bus.i_address, 32'hFFFF_FFFC);
            if (k == 5) begin
                chk("wrap_req", bus.i_req, 1'b1);
                chk("wrap_zero_addr", bus.i_address, 32'h0000_0000);
            end
            if (k == 7)
                chk("wrap_zero_head", bus.ins_pc, 32'h0000_0000);
        end

        // Reset with two requests in flight; stale responses arrive during and just after reset.
        rom_lat = 2;
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0);
        rom_q.delete();
        last_due = 0;
        stale_n  = 3;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        rom_lat = 1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            if (i == 2) begin
                chk("post_rst_valid", bus.ins_valid, 1'b1);
                chk("post_rst_pc", bus.ins_pc, RESET_PC);
                chk("post_rst_data", bus.ins_data, rom_word(RESET_PC));
            end
        end

        // Random traffic: variable latency, stalls, aligned/misaligned/wrapping redirects.
        rom_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        j;
            logic        st;
            logic [31:0] ja;
            int          sel;
            j   = ($urandom_range(0, 99) < 4);
            st  = ($urandom_range(0, 99) < 30);
            sel = int'($urandom_range(0, 99));
            if (sel < 70)
                ja = $urandom & 32'h0000_FFFC;
            else if (sel < 85)
                ja = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
            else
                ja = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
            step(1'b0, j, ja, st);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
